bus_source_arbiter: RTL and testbench

Round-robin arbiter that shares the 32-bit datapath bus between several control requesters, such as the instruction sequencer, the I/O handler and the debug port. It drives the 5-bit source-select code into the 32-to-1 bus multiplexer. It guarantees that exactly one source, or none, is on the bus, and it bounds how long any single owner can hold the bus. Sits between the control units and the bus multiplexer select input.

---
 rtl/bus_source_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_bus_source_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bus_source_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bus_source_arbiter
// Brief    : Round-robin arbiter sharing the 32-bit datapath bus. Masks
//            requesters presenting invalid source codes, latches the winner's
//            code into the bus-mux select and bounds ownership to MAX_HOLD
//            cycles whenever another requester is waiting.
// Revision : 1.0 - initial release
// ============================================================================
module bus_source_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clock,
  input  logic                   clear_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [5*NUM_REQ-1:0]   src_code,
  output logic [NUM_REQ-1:0]     grant,
  output logic [4:0]             select_signal,
  output logic                   bus_busy,
  output logic [2:0]             owner,
  output logic [NUM_REQ-1:0]     bad_req
);

  localparam logic [7:0] C_MAX_HOLD = 8'(MAX_HOLD);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t               r_state, w_nxtState;
  logic [NUM_REQ-1:0]   r_grant, w_nxtGrant;
  logic [4:0]           r_select, w_nxtSelect;
  logic [2:0]           r_owner, w_nxtOwner;
  logic [2:0]           r_rrPtr, w_nxtRrPtr;
  logic [7:0]           r_holdCnt, w_nxtHoldCnt;

  logic [NUM_REQ-1:0]   w_valid;
  logic [NUM_REQ-1:0]   w_eligible;
  logic [NUM_REQ-1:0]   w_ownerMask;
  logic [NUM_REQ-1:0]   w_cand;
  logic                 w_ownerReq;
  logic                 w_found;
  logic [2:0]           w_winner;
  logic [3:0]           w_idx;
  logic [NUM_REQ-1:0]   w_winGrant;
  logic [4:0]           w_winCode;
  logic [2:0]           w_winNextPtr;

  // Per-requester source-code validity: only codes 1..25 name a real source.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_valid
      assign w_valid[gi] = (src_code[5*gi +: 5] >= 5'd1) &&
                           (src_code[5*gi +: 5] <= 5'd25);
    end
  endgenerate

  assign w_eligible = req & w_valid;
  assign bad_req    = req & ~w_valid;

  // Decode the current owner into a mask and pick out its raw request level.
  always_comb begin
    w_ownerMask = '0;
    w_ownerReq  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == r_owner) begin
        w_ownerMask[i] = 1'b1;
        w_ownerReq     = req[i];
      end
    end
  end

  // While owned, the owner is excluded so a handoff never re-selects it.
  assign w_cand = (r_state == OWNED) ? (w_eligible & ~w_ownerMask) : w_eligible;

  // First candidate at or above rrPtr, wrapping; rrPtr sits just past the
  // owner while owned, so this is also the "next after owner" search.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rrPtr} + 4'(k);
      if (w_idx >= 4'(NUM_REQ)) begin
        w_idx = w_idx - 4'(NUM_REQ);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && (4'(i) == w_idx) && w_cand[i]) begin
          w_found  = 1'b1;
          w_winner = 3'(i);
        end
      end
    end
  end

  // One-hot grant and source code belonging to the winner.
  always_comb begin
    w_winGrant = '0;
    w_winCode  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == w_winner) begin
        w_winGrant[i] = 1'b1;
        w_winCode     = src_code[5*i +: 5];
      end
    end
  end

  assign w_winNextPtr = (w_winner == 3'(NUM_REQ - 1)) ? 3'd0 : (w_winner + 3'd1);

  // Next-state logic: retain, hand off (release or hold expiry) or go idle.
  always_comb begin
    w_nxtState   = r_state;
    w_nxtGrant   = r_grant;
    w_nxtSelect  = r_select;
    w_nxtOwner   = r_owner;
    w_nxtRrPtr   = r_rrPtr;
    w_nxtHoldCnt = r_holdCnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nxtState   = OWNED;
          w_nxtGrant   = w_winGrant;
          w_nxtSelect  = w_winCode;
          w_nxtOwner   = w_winner;
          w_nxtRrPtr   = w_winNextPtr;
          w_nxtHoldCnt = 8'd1;
        end
      end
      OWNED: begin
        if (w_ownerReq && !((r_holdCnt == C_MAX_HOLD) && w_found)) begin
          if (r_holdCnt != C_MAX_HOLD) begin
            w_nxtHoldCnt = r_holdCnt + 8'd1;
          end
        end else if (w_found) begin
          w_nxtGrant   = w_winGrant;
          w_nxtSelect  = w_winCode;
          w_nxtOwner   = w_winner;
          w_nxtRrPtr   = w_winNextPtr;
          w_nxtHoldCnt = 8'd1;
        end else begin
          w_nxtState   = IDLE;
          w_nxtGrant   = '0;
          w_nxtSelect  = '0;
          w_nxtHoldCnt = '0;
        end
      end
      default: begin
        w_nxtState   = IDLE;
        w_nxtGrant   = '0;
        w_nxtSelect  = '0;
        w_nxtHoldCnt = '0;
      end
    endcase
  end

  // State and output registers; owner survives going idle.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_select  <= '0;
      r_owner   <= '0;
      r_rrPtr   <= '0;
      r_holdCnt <= '0;
    end else begin
      r_state   <= w_nxtState;
      r_grant   <= w_nxtGrant;
      r_select  <= w_nxtSelect;
      r_owner   <= w_nxtOwner;
      r_rrPtr   <= w_nxtRrPtr;
      r_holdCnt <= w_nxtHoldCnt;
    end
  end

  assign grant         = r_grant;
  assign select_signal = r_select;
  assign owner         = r_owner;
  assign bus_busy      = |r_grant;

endmodule
`default_nettype wire

// File: tb/tb_bus_source_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bus_source_arbiter
// Brief    : Directed self-checking bench for bus_source_arbiter
//            (NUM_REQ = 4, MAX_HOLD = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_source_arbiter;

  localparam int NREQ = 4;
  localparam int MAXH = 4;

  logic              clock = 1'b0;
  logic              clear_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [5*NREQ-1:0] src_code = '0;
  logic [NREQ-1:0]   grant;
  logic [4:0]        select_signal;
  logic              bus_busy;
  logic [2:0]        owner;
  logic [NREQ-1:0]   bad_req;

  int numChecks = 0;
  int numErrors = 0;

  bus_source_arbiter #(
    .NUM_REQ  (NREQ),
    .MAX_HOLD (MAXH)
  ) dut (
    .clock         (clock),
    .clear_n       (clear_n),
    .req           (req),
    .src_code      (src_code),
    .grant         (grant),
    .select_signal (select_signal),
    .bus_busy      (bus_busy),
    .owner         (owner),
    .bad_req       (bad_req)
  );

  // Free-running 100 MHz clock.
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic setCode(input int i, input logic [4:0] c);
    src_code[5*i +: 5] = c;
  endtask

  task automatic checkBus(input string tag, input logic [3:0] expGrant,
                          input logic [4:0] expSel, input logic [2:0] expOwner);
    checkVal({tag, ".grant"}, 32'(grant), 32'(expGrant));
    checkVal({tag, ".select"}, 32'(select_signal), 32'(expSel));
    checkVal({tag, ".busy"}, 32'(bus_busy), 32'(expGrant != 4'b0000));
    checkVal({tag, ".owner"}, 32'(owner), 32'(expOwner));
  endtask

  initial begin
    // Reset state
    tick;
    tick;
    checkBus("reset", 4'b0000, 5'd0, 3'd0);

    // Single request, 1-cycle latency, then release
    req = 4'b0001;
    setCode(0, 5'd21);
    clear_n = 1'b1;
    tick;
    checkBus("single_grant", 4'b0001, 5'd21, 3'd0);
    req = 4'b0000;
    tick;
    checkBus("single_release", 4'b0000, 5'd0, 3'd0);

    // Round-robin: pointer now at 1; each owner drops after 2 cycles
    setCode(0, 5'd1);
    setCode(1, 5'd2);
    setCode(2, 5'd3);
    setCode(3, 5'd4);
    req = 4'b1111;
    tick;
    checkBus("rr_r1", 4'b0010, 5'd2, 3'd1);
    tick;
    checkBus("rr_r1_hold", 4'b0010, 5'd2, 3'd1);
    req = 4'b1101;
    tick;
    checkBus("rr_r2", 4'b0100, 5'd3, 3'd2);
    tick;
    checkBus("rr_r2_hold", 4'b0100, 5'd3, 3'd2);
    req = 4'b1001;
    tick;
    checkBus("rr_r3", 4'b1000, 5'd4, 3'd3);
    tick;
    checkBus("rr_r3_hold", 4'b1000, 5'd4, 3'd3);
    req = 4'b0001;
    tick;
    checkBus("rr_r0", 4'b0001, 5'd1, 3'd0);
    tick;
    checkBus("rr_r0_hold", 4'b0001, 5'd1, 3'd0);
    req = 4'b0000;
    tick;
    checkBus("rr_idle", 4'b0000, 5'd0, 3'd0);

    // Hold limit: pointer at 1, so requester 1 first; 4 cycles each
    req = 4'b0011;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (k < 4 || k >= 8) checkBus("hold_rot", 4'b0010, 5'd2, 3'd1);
      else                 checkBus("hold_rot", 4'b0001, 5'd1, 3'd0);
    end
    // Requester 0 alone keeps the bus well past MAX_HOLD
    req = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      tick;
      checkBus("hold_alone", 4'b0001, 5'd1, 3'd0);
    end
    req = 4'b0000;
    tick;
    checkBus("hold_idle", 4'b0000, 5'd0, 3'd0);

    // Invalid codes on requester 2 are flagged and never granted
    req = 4'b0100;
    setCode(2, 5'd0);
    #1;
    checkVal("bad_code0", 32'(bad_req), 32'h4);
    tick;
    checkBus("inv_code0", 4'b0000, 5'd0, 3'd0);
    setCode(2, 5'd26);
    #1;
    checkVal("bad_code26", 32'(bad_req), 32'h4);
    tick;
    checkBus("inv_code26", 4'b0000, 5'd0, 3'd0);
    setCode(2, 5'd31);
    #1;
    checkVal("bad_code31", 32'(bad_req), 32'h4);
    tick;
    checkBus("inv_code31", 4'b0000, 5'd0, 3'd0);
    setCode(2, 5'd17);
    #1;
    checkVal("bad_code17", 32'(bad_req), 32'h0);
    tick;
    checkBus("valid_code17", 4'b0100, 5'd17, 3'd2);
    req = 4'b0000;
    tick;
    checkBus("inv_idle", 4'b0000, 5'd0, 3'd2);

    // Latched code is stable while owned
    req = 4'b0010;
    setCode(1, 5'd5);
    tick;
    checkBus("latch_grant", 4'b0010, 5'd5, 3'd1);
    setCode(1, 5'd9);
    tick;
    checkBus("latch_hold1", 4'b0010, 5'd5, 3'd1);
    tick;
    checkBus("latch_hold2", 4'b0010, 5'd5, 3'd1);
    req = 4'b0000;
    tick;
    checkBus("latch_release", 4'b0000, 5'd0, 3'd1);

    // Asynchronous reset while requester 3 owns the bus (code 25 is valid)
    req = 4'b1000;
    setCode(3, 5'd25);
    tick;
    checkBus("pre_reset", 4'b1000, 5'd25, 3'd3);
    clear_n = 1'b0;
    #1;
    checkBus("reset_mid", 4'b0000, 5'd0, 3'd0);
    req = 4'b1001;
    setCode(0, 5'd21);
    tick;
    checkBus("reset_held", 4'b0000, 5'd0, 3'd0);
    clear_n = 1'b1;
    tick;
    checkBus("after_reset", 4'b0001, 5'd21, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
`default_nettype wire
